sseg_scan_controller: RTL and testbench

SSEG_SCAN_CONTROLLER -- requirements
Module: sseg_scan_controller

---
 rtl/sseg_scan_controller.sv | 192 +++++++++++++++++++
 tb/tb_sseg_scan_controller.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_controller.sv
// sseg_scan_controller
// Converts an 8-bit value to BCD with a sequential double-dabble engine,
// then multiplexes the three decimal digits (plus a sign digit) onto a
// 4-digit common-anode seven-segment display.
// Build option: define SSEG_SIGNED_EN to treat value_in as two's complement
// and show a minus sign on digit 3 for negative values.
module sseg_scan_controller #(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] value_in,
  input  logic       wr,
  output logic       busy,
  output logic       done,
  output logic [7:0] seg,
  output logic [3:0] an
);

  localparam logic [15:0] SCAN_LAST  = 16'(SCAN_DIV - 1);
  localparam logic [7:0]  GLYPH_BLANK = 8'hFF;
  localparam logic [7:0]  GLYPH_MINUS = 8'hBF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [2:0]  bit_cnt_reg;
  logic [7:0]  shift_reg;
  logic [11:0] bcd_reg;
  logic [11:0] bcd_adj;
  logic [11:0] disp_bcd_reg;
  logic        done_reg;
  logic [15:0] scan_cnt_reg;
  logic [1:0]  idx_reg;
  logic [7:0]  mag_in;
  logic [7:0]  raw_glyph [3];
  logic [7:0]  digit_glyph [4];

  // Segment pattern for one BCD nibble; out-of-range nibbles are blank
  function automatic logic [7:0] glyph(input logic [3:0] d);
    logic [7:0] g;
    case (d)
      4'd0:    g = 8'hC0;
      4'd1:    g = 8'hF9;
      4'd2:    g = 8'hA4;
      4'd3:    g = 8'hB0;
      4'd4:    g = 8'h99;
      4'd5:    g = 8'h92;
      4'd6:    g = 8'h82;
      4'd7:    g = 8'hF8;
      4'd8:    g = 8'h80;
      4'd9:    g = 8'h90;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

`ifdef SSEG_SIGNED_EN
  logic sign_in;
  logic pend_neg_reg;
  logic disp_neg_reg;

  // Magnitude of a two's complement input; -128 maps to 128, which still fits
  assign sign_in = value_in[7];
  assign mag_in  = value_in[7] ? (~value_in + 8'd1) : value_in;
`else
  assign mag_in = value_in;
`endif

  assign busy = (state_reg != IDLE);
  assign done = done_reg;

  // Conversion state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: eight shift cycles, then one commit cycle
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (wr) state_next = CONV;
      CONV:    if (bit_cnt_reg == 3'd7) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5)
                                  ? (bcd_reg[gi*4 +: 4] + 4'd3)
                                  : bcd_reg[gi*4 +: 4];
    end
  endgenerate

  // Conversion datapath and display registers; the display only changes in
  // COMMIT so partial conversion results never reach the segments
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_reg  <= 3'd0;
      shift_reg    <= 8'd0;
      bcd_reg      <= 12'd0;
      disp_bcd_reg <= 12'd0;
      done_reg     <= 1'b0;
`ifdef SSEG_SIGNED_EN
      pend_neg_reg <= 1'b0;
      disp_neg_reg <= 1'b0;
`endif
    end else begin
      done_reg <= (state_reg == COMMIT);
      case (state_reg)
        IDLE: begin
          if (wr) begin
            shift_reg   <= mag_in;
            bcd_reg     <= 12'd0;
            bit_cnt_reg <= 3'd0;
`ifdef SSEG_SIGNED_EN
            pend_neg_reg <= sign_in;
`endif
          end
        end
        CONV: begin
          bcd_reg     <= {bcd_adj[10:0], shift_reg[7]};
          shift_reg   <= {shift_reg[6:0], 1'b0};
          bit_cnt_reg <= bit_cnt_reg + 3'd1;
        end
        COMMIT: begin
          disp_bcd_reg <= bcd_reg;
`ifdef SSEG_SIGNED_EN
          disp_neg_reg <= pend_neg_reg;
`endif
        end
        default: ;
      endcase
    end
  end

  // Digit scan timer: free-running, never disturbed by writes
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_reg <= 16'd0;
      idx_reg      <= 2'd0;
    end else if (scan_cnt_reg == SCAN_LAST) begin
      scan_cnt_reg <= 16'd0;
      idx_reg      <= idx_reg + 2'd1;
    end else begin
      scan_cnt_reg <= scan_cnt_reg + 16'd1;
    end
  end

  // Raw glyphs for ones, tens and hundreds
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_glyph
      assign raw_glyph[gi] = glyph(disp_bcd_reg[gi*4 +: 4]);
    end
  endgenerate

  // Leading-zero blanking and the sign digit
  always_comb begin
    digit_glyph[0] = raw_glyph[0];
    digit_glyph[1] = raw_glyph[1];
    digit_glyph[2] = raw_glyph[2];
    digit_glyph[3] = GLYPH_BLANK;
    if (disp_bcd_reg[11:8] == 4'd0) begin
      digit_glyph[2] = GLYPH_BLANK;
      if (disp_bcd_reg[7:4] == 4'd0) begin
        digit_glyph[1] = GLYPH_BLANK;
      end
    end
`ifdef SSEG_SIGNED_EN
    if (disp_neg_reg) begin
      digit_glyph[3] = GLYPH_MINUS;
    end
`endif
  end

  // Outputs decode straight from registers so seg and an move together
  assign an  = ~(4'b0001 << idx_reg);
  assign seg = digit_glyph[idx_reg];

endmodule

// File: tb/tb_sseg_scan_controller.sv
// Scoreboard bench for sseg_scan_controller: accepted writes push the expected
// glyph set; each done pulse pops it. A cycle model tracks scan and busy timing.
module tb_sseg_scan_controller;
  localparam int SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] value_in = 8'd0;
  logic       busy;
  logic       done;
  logic [7:0] seg;
  logic [3:0] an;

  sseg_scan_controller #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk),
    .rst(rst),
    .value_in(value_in),
    .wr(wr),
    .busy(busy),
    .done(done),
    .seg(seg),
    .an(an)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          acc_cyc;
    int          val;
    logic [31:0] glyphs;
  } txn_t;

  txn_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          mcnt = 0;
  int          midx = 0;
  int          m_left = 0;
  logic        exp_done = 1'b0;
  logic [31:0] exp_glyphs = {8'hFF, 8'hFF, 8'hFF, 8'hC0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [7:0] glyph_of(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [31:0] expect_glyphs(input logic [7:0] v);
    int m;
    int h;
    int t;
    int o;
    logic neg;
    logic [31:0] g;
`ifdef SSEG_SIGNED_EN
    m = $signed(v);
    neg = (m < 0);
    if (neg) m = -m;
`else
    m = v;
    neg = 1'b0;
`endif
    h = m / 100;
    t = (m / 10) % 10;
    o = m % 10;
    g[7:0]   = glyph_of(o);
    g[15:8]  = (h == 0 && t == 0) ? 8'hFF : glyph_of(t);
    g[23:16] = (h == 0) ? 8'hFF : glyph_of(h);
    g[31:24] = neg ? 8'hBF : 8'hFF;
    return g;
  endfunction

  // One clock edge: advance the model with the inputs sampled at that edge,
  // then compare every DUT output
  task automatic tick();
    txn_t t;
    logic [3:0] exp_an;
    @(posedge clk);
    #1;
    cyc++;
    exp_done = 1'b0;
    if (rst) begin
      mcnt = 0;
      midx = 0;
      m_left = 0;
      sb.delete();
      exp_glyphs = {8'hFF, 8'hFF, 8'hFF, 8'hC0};
    end else begin
      if (mcnt == SCAN_DIV - 1) begin
        mcnt = 0;
        midx = (midx + 1) % 4;
      end else begin
        mcnt++;
      end
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) exp_done = 1'b1;
      end else if (wr) begin
        m_left = 9;
        t.acc_cyc = cyc;
        t.val = value_in;
        t.glyphs = expect_glyphs(value_in);
        sb.push_back(t);
      end
    end
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("done_without_txn", 32'd1, 32'd0);
      end else begin
        t = sb.pop_front();
        check("latency", cyc - t.acc_cyc, 32'd9);
        exp_glyphs = t.glyphs;
        $display("txn value=%0d accepted=%0d done=%0d glyphs=%h", t.val, t.acc_cyc, cyc, t.glyphs);
      end
    end
    exp_an = ~(4'b0001 << midx);
    check("busy", busy, m_left > 0);
    check("done", done, exp_done);
    check("an", an, exp_an);
    check("seg", seg, exp_glyphs[midx*8 +: 8]);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic write(input logic [7:0] v);
    value_in = v;
    wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  initial begin
    logic [7:0] bvals [6];
    int guard;
    bvals = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd255};

    // Reset and free-running scan of the zero display
    run(2);
    rst = 1'b0;
    run(20);

    // Full-scale value
    write(8'hFF);
    run(28);

    // Write during busy is dropped, then accepted after done
    write(8'd7);
    run(3);
    write(8'd200);
    run(26);
    write(8'd200);
    run(26);

    // Write on the first idle cycle after busy falls
    write(8'd55);
    run(9);
    write(8'd123);
    run(26);

    // Blanking boundaries
    foreach (bvals[i]) begin
      write(bvals[i]);
      run(13);
    end

    // Reset in the middle of a conversion aborts it
    write(8'd99);
    run(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run(20);
    check("abort_sb_empty", sb.size(), 32'd0);

    // Reset wins over a simultaneous write
    rst = 1'b1;
    value_in = 8'd77;
    wr = 1'b1;
    tick();
    rst = 1'b0;
    wr = 1'b0;
    run(12);

    // Write mid-scan at digit index 2
    guard = 0;
    while (!(midx == 2 && mcnt == 1) && guard < 64) begin
      tick();
      guard++;
    end
    check("scan_sync_reached", guard < 64, 1'b1);
    write(8'd42);
    run(30);

    // Sign-relevant patterns (plain magnitudes in the unsigned build)
    write(8'h80);
    run(26);
    write(8'hF6);
    run(26);

    // Random writes, some landing while busy
    repeat (20) begin
      value_in = 8'($urandom_range(0, 255));
      wr = ($urandom_range(0, 1) == 1);
      tick();
    end
    wr = 1'b0;
    run(30);

    check("final_sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
